// File: rtl/huffman_bigvalues_sequencer.sv
// rtl/huffman_bigvalues_sequencer.sv - MP3 big_values Huffman pair sequencer
// Selects the table per pair, streams bits to the external decoder and serialises (x,y) into samples.
module huffman_bigvalues_sequencer #(
  parameter int MAX_PAIRS = 288,
  parameter int BUDGET_W  = 12,
  parameter int IDX_W     = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [8:0]          big_values,
  input  logic [IDX_W-1:0]    region1_start,
  input  logic [IDX_W-1:0]    region2_start,
  input  logic [4:0]          table_sel0,
  input  logic [4:0]          table_sel1,
  input  logic [4:0]          table_sel2,
  input  logic [BUDGET_W-1:0] bit_budget,
  input  logic                bit_valid,
  input  logic                bit_data,
  output logic                bit_ready,
  output logic [4:0]          ht_sel,
  output logic                dec_valid,
  output logic                dec_data,
  input  logic                dec_done,
  input  logic signed [15:0]  dec_x,
  input  logic signed [15:0]  dec_y,
  output logic                sample_valid,
  output logic [IDX_W-1:0]    sample_idx,
  output logic signed [15:0]  sample_val,
  output logic [BUDGET_W-1:0] bits_left,
  output logic                busy,
  output logic                done,
  output logic                error
);

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_FEED, S_EMIT_ZX, S_EMIT_Y, S_DONE
  } state_t;

  state_t state, state_n;

  logic [8:0]         pair;
  logic [8:0]         bv;
  logic [IDX_W-1:0]   r1, r2;
  logic [4:0]         t0, t1, t2;
  logic signed [15:0] y_hold;

  logic [IDX_W-1:0] pair_idx;
  logic [4:0]       tbl_pick;
  logic             tbl_bad;
  logic [4:0]       tbl_eff;
  logic             last_pair;

  always_comb begin
    pair_idx  = IDX_W'({pair, 1'b0});
    last_pair = ((pair + 9'd1) == bv);
    if (pair_idx < r1)      tbl_pick = t0;
    else if (pair_idx < r2) tbl_pick = t1;
    else                    tbl_pick = t2;
    tbl_bad = (tbl_pick == 5'd4) || (tbl_pick == 5'd14);
    tbl_eff = tbl_bad ? 5'd0 : tbl_pick;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n      = state;
    bit_ready    = 1'b0;
    dec_valid    = 1'b0;
    dec_data     = 1'b0;
    sample_valid = 1'b0;
    sample_idx   = '0;
    sample_val   = '0;
    done         = 1'b0;
    busy         = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (start) state_n = (big_values == 9'd0) ? S_DONE : S_SELECT;
      end
      S_SELECT: begin
        state_n = (tbl_eff == 5'd0) ? S_EMIT_ZX : S_FEED;
      end
      S_FEED: begin
        // The decoder clears itself on dec_done, so no bit may be offered that cycle.
        bit_ready = ~dec_done & (bits_left != '0);
        dec_valid = bit_valid & bit_ready;
        dec_data  = bit_data;
        if (dec_done) begin
          sample_valid = 1'b1;
          sample_idx   = pair_idx;
          sample_val   = dec_x;
          state_n      = S_EMIT_Y;
        end else if (bits_left == '0) begin
          state_n = S_DONE;
        end
      end
      S_EMIT_ZX: begin
        sample_valid = 1'b1;
        sample_idx   = pair_idx;
        state_n      = S_EMIT_Y;
      end
      S_EMIT_Y: begin
        sample_valid = 1'b1;
        sample_idx   = pair_idx | IDX_W'(1);
        sample_val   = y_hold;
        state_n      = last_pair ? S_DONE : S_SELECT;
      end
      S_DONE: begin
        done    = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pair      <= '0;
      bv        <= '0;
      r1        <= '0;
      r2        <= '0;
      t0        <= '0;
      t1        <= '0;
      t2        <= '0;
      ht_sel    <= '0;
      bits_left <= '0;
      y_hold    <= '0;
      error     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            bv        <= (big_values > 9'(MAX_PAIRS)) ? 9'(MAX_PAIRS) : big_values;
            error     <= (big_values > 9'(MAX_PAIRS));
            r1        <= region1_start;
            r2        <= region2_start;
            t0        <= table_sel0;
            t1        <= table_sel1;
            t2        <= table_sel2;
            bits_left <= bit_budget;
            pair      <= '0;
          end
        end
        S_SELECT: begin
          ht_sel <= tbl_eff;
          if (tbl_bad) error <= 1'b1;
        end
        S_FEED: begin
          if (dec_valid) bits_left <= bits_left - BUDGET_W'(1);
          if (dec_done)               y_hold <= dec_y;
          else if (bits_left == '0)   error  <= 1'b1;
        end
        S_EMIT_ZX: y_hold <= '0;
        S_EMIT_Y:  pair   <= pair + 9'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_huffman_bigvalues_sequencer.sv
// tb/tb_huffman_bigvalues_sequencer.sv - directed bench for huffman_bigvalues_sequencer
// Models a bit source and a fixed-length toy decoder around the sequencer.
module tb_huffman_bigvalues_sequencer;
  localparam int IDX_W = 10;
  localparam int BW    = 12;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [8:0]        big_values;
  logic [IDX_W-1:0]  region1_start, region2_start;
  logic [4:0]        table_sel0, table_sel1, table_sel2;
  logic [BW-1:0]     bit_budget;
  logic              bit_valid, bit_data, bit_ready;
  logic [4:0]        ht_sel;
  logic              dec_valid, dec_data, dec_done;
  logic signed [15:0] dec_x, dec_y;
  logic              sample_valid;
  logic [IDX_W-1:0]  sample_idx;
  logic signed [15:0] sample_val;
  logic [BW-1:0]     bits_left;
  logic              busy, done, error;

  int checks = 0;
  int failures = 0;

  huffman_bigvalues_sequencer #(.MAX_PAIRS(288), .BUDGET_W(BW), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst), .start(start), .big_values(big_values),
    .region1_start(region1_start), .region2_start(region2_start),
    .table_sel0(table_sel0), .table_sel1(table_sel1), .table_sel2(table_sel2),
    .bit_budget(bit_budget), .bit_valid(bit_valid), .bit_data(bit_data), .bit_ready(bit_ready),
    .ht_sel(ht_sel), .dec_valid(dec_valid), .dec_data(dec_data), .dec_done(dec_done),
    .dec_x(dec_x), .dec_y(dec_y), .sample_valid(sample_valid), .sample_idx(sample_idx),
    .sample_val(sample_val), .bits_left(bits_left), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  // Bit source: stream bit i is offered at position i; optional every-other-cycle gating.
  logic [31:0] stream;
  int          stream_len;
  logic        gate_mode;
  logic        phase = 1'b0;
  int          ptr = 0;
  assign bit_valid = (ptr < stream_len) && (!gate_mode || phase);
  assign bit_data  = stream[ptr[4:0]];

  always @(posedge clk) begin
    phase <= ~phase;
    if (!busy) ptr <= 0;
    else if (bit_valid && bit_ready) ptr <= ptr + 1;
  end

  // Toy decoder: signals completion the cycle after need_bits bits were accepted.
  int                 need_bits;
  logic signed [15:0] model_x, model_y;
  int                 dec_cnt = 0;
  int                 total_dv = 0;
  logic [7:0]         rx_bits = '0;
  assign dec_done = busy && (dec_cnt == need_bits);
  assign dec_x    = dec_done ? model_x : 16'sd0;
  assign dec_y    = dec_done ? model_y : 16'sd0;

  always @(posedge clk) begin
    if (dec_valid) total_dv <= total_dv + 1;
    if (!busy || dec_done) dec_cnt <= 0;
    else if (dec_valid) begin
      rx_bits[dec_cnt[2:0]] <= dec_data;
      dec_cnt <= dec_cnt + 1;
    end
  end

  int         s_idx[$];
  int         s_val[$];
  logic [4:0] s_tbl[$];
  int         done_cnt = 0;
  int         viol = 0;

  always @(negedge clk) begin
    if (sample_valid) begin
      s_idx.push_back(int'(sample_idx));
      s_val.push_back(int'(sample_val));
      if (!sample_idx[0]) s_tbl.push_back(ht_sel);
    end
    if (done) done_cnt <= done_cnt + 1;
    if (dec_valid && (dec_done || !busy)) viol <= viol + 1;
  end

  task automatic do_start(input logic [8:0] bv, input logic [IDX_W-1:0] r1, input logic [IDX_W-1:0] r2,
                          input logic [4:0] ta, input logic [4:0] tb, input logic [4:0] tc,
                          input logic [BW-1:0] budget);
    @(negedge clk);
    big_values = bv; region1_start = r1; region2_start = r2;
    table_sel0 = ta; table_sel1 = tb; table_sel2 = tc; bit_budget = budget;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int max_cycles, output bit got);
    got = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    checks++;
    if ({busy, bit_ready, dec_valid, sample_valid, done, error} !== 6'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b want=000000", {busy, bit_ready, dec_valid, sample_valid, done, error});
    end
    checks++;
    if (bits_left !== '0 || ht_sel !== '0) begin
      failures++;
      $display("FAIL reset_regs bits_left=%0d ht_sel=%0d want 0/0", bits_left, ht_sel);
    end
    checks++;
    if (sample_idx !== '0 || sample_val !== '0 || dec_data !== 1'b0) begin
      failures++;
      $display("FAIL reset_sample idx=%0d val=%0d dec_data=%b want 0", sample_idx, sample_val, dec_data);
    end
  endtask

  task automatic test_single_pair(input string tag, input logic gated);
    int dv0, q0, d0;
    bit got;
    stream = 32'b01011; stream_len = 8; gate_mode = gated;
    need_bits = 5; model_x = 16'sd0; model_y = 16'sd1;
    dv0 = total_dv; q0 = s_idx.size(); d0 = done_cnt;
    do_start(9'd1, 10'd576, 10'd576, 5'd28, 5'd0, 5'd0, 12'd20);
    wait_done(200, got);
    checks++;
    if (!got) begin failures++; $display("FAIL %s_done_timeout got=0 want=1", tag); end
    checks++;
    if (total_dv - dv0 != 5) begin failures++; $display("FAIL %s_bits got=%0d want=5", tag, total_dv - dv0); end
    checks++;
    if (rx_bits[4:0] !== 5'b01011) begin failures++; $display("FAIL %s_rx_bits got=%b want=01011", tag, rx_bits[4:0]); end
    checks++;
    if (s_idx.size() - q0 != 2) begin
      failures++; $display("FAIL %s_sample_count got=%0d want=2", tag, s_idx.size() - q0);
    end else if (s_idx[q0] != 0 || s_val[q0] != 0 || s_idx[q0+1] != 1 || s_val[q0+1] != 1) begin
      failures++;
      $display("FAIL %s_samples got=(%0d,%0d)(%0d,%0d) want=(0,0)(1,1)", tag, s_idx[q0], s_val[q0], s_idx[q0+1], s_val[q0+1]);
    end
    checks++;
    if (bits_left !== 12'd15) begin failures++; $display("FAIL %s_bits_left got=%0d want=15", tag, bits_left); end
    checks++;
    if (error !== 1'b0) begin failures++; $display("FAIL %s_error got=%b want=0", tag, error); end
    checks++;
    if (done_cnt - d0 != 1) begin failures++; $display("FAIL %s_done_pulses got=%0d want=1", tag, done_cnt - d0); end
    gate_mode = 1'b0;
  endtask

  task automatic test_region_switch;
    int dv0, q0, t0q;
    bit got;
    int exp_val[6] = '{0, 0, -5, 7, 0, 0};
    logic [4:0] exp_tbl[3] = '{5'd0, 5'd28, 5'd0};
    stream = 32'b01011; stream_len = 8; gate_mode = 1'b0;
    need_bits = 5; model_x = -16'sd5; model_y = 16'sd7;
    dv0 = total_dv; q0 = s_idx.size(); t0q = s_tbl.size();
    do_start(9'd3, 10'd2, 10'd4, 5'd0, 5'd28, 5'd0, 12'd40);
    wait_done(200, got);
    checks++;
    if (!got) begin failures++; $display("FAIL region_done_timeout got=0 want=1"); end
    checks++;
    if (s_idx.size() - q0 != 6) begin
      failures++; $display("FAIL region_sample_count got=%0d want=6", s_idx.size() - q0);
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (s_idx[q0+i] != i || s_val[q0+i] != exp_val[i]) begin
          failures++;
          $display("FAIL region_sample%0d got=(%0d,%0d) want=(%0d,%0d)", i, s_idx[q0+i], s_val[q0+i], i, exp_val[i]);
        end
      end
    end
    checks++;
    if (s_tbl.size() - t0q != 3) begin
      failures++; $display("FAIL region_tbl_count got=%0d want=3", s_tbl.size() - t0q);
    end else if (s_tbl[t0q] !== exp_tbl[0] || s_tbl[t0q+1] !== exp_tbl[1] || s_tbl[t0q+2] !== exp_tbl[2]) begin
      failures++;
      $display("FAIL region_ht_sel got=%0d,%0d,%0d want=0,28,0", s_tbl[t0q], s_tbl[t0q+1], s_tbl[t0q+2]);
    end
    checks++;
    if (total_dv - dv0 != 5 || bits_left !== 12'd35) begin
      failures++; $display("FAIL region_bits consumed=%0d bits_left=%0d want=5/35", total_dv - dv0, bits_left);
    end
  endtask

  task automatic test_budget_exhaust;
    int dv0, q0, d0;
    bit got;
    stream = 32'b01011; stream_len = 8; gate_mode = 1'b0;
    need_bits = 5; model_x = 16'sd3; model_y = 16'sd3;
    dv0 = total_dv; q0 = s_idx.size(); d0 = done_cnt;
    do_start(9'd1, 10'd576, 10'd576, 5'd28, 5'd0, 5'd0, 12'd3);
    wait_done(100, got);
    checks++;
    if (!got || done_cnt - d0 != 1) begin
      failures++; $display("FAIL budget_done got=%0d pulses=%0d want=1/1", got, done_cnt - d0);
    end
    checks++;
    if (s_idx.size() != q0) begin failures++; $display("FAIL budget_samples got=%0d want=0", s_idx.size() - q0); end
    checks++;
    if (bits_left !== 12'd0 || total_dv - dv0 != 3) begin
      failures++; $display("FAIL budget_bits bits_left=%0d consumed=%0d want=0/3", bits_left, total_dv - dv0);
    end
    checks++;
    if (error !== 1'b1) begin failures++; $display("FAIL budget_error got=%b want=1", error); end
  endtask

  task automatic test_clamp;
    int dv0, q0, gaps;
    bit got;
    need_bits = 5; stream_len = 0;
    dv0 = total_dv; q0 = s_idx.size();
    do_start(9'd300, 10'd576, 10'd576, 5'd0, 5'd0, 5'd0, 12'd100);
    wait_done(2000, got);
    checks++;
    if (!got) begin failures++; $display("FAIL clamp_done_timeout got=0 want=1"); end
    checks++;
    if (error !== 1'b1) begin failures++; $display("FAIL clamp_error got=%b want=1", error); end
    checks++;
    if (s_idx.size() - q0 != 576) begin
      failures++; $display("FAIL clamp_count got=%0d want=576", s_idx.size() - q0);
    end else begin
      gaps = 0;
      for (int i = 0; i < 576; i++)
        if (s_idx[q0+i] != i || s_val[q0+i] != 0) gaps++;
      checks++;
      if (gaps != 0) begin failures++; $display("FAIL clamp_sequence bad_entries=%0d want=0", gaps); end
      checks++;
      if (s_idx[q0+575] != 575) begin failures++; $display("FAIL clamp_last_idx got=%0d want=575", s_idx[q0+575]); end
    end
    checks++;
    if (bits_left !== 12'd100 || total_dv != dv0) begin
      failures++; $display("FAIL clamp_bits bits_left=%0d consumed=%0d want=100/0", bits_left, total_dv - dv0);
    end
  endtask

  task automatic test_invalid_table;
    int dv0, q0, t0q;
    bit got;
    stream = 32'b01011; stream_len = 8; need_bits = 5;
    dv0 = total_dv; q0 = s_idx.size(); t0q = s_tbl.size();
    do_start(9'd1, 10'd576, 10'd576, 5'd4, 5'd0, 5'd0, 12'd50);
    wait_done(100, got);
    checks++;
    if (!got || error !== 1'b1) begin failures++; $display("FAIL invalid_error done=%0d error=%b want=1/1", got, error); end
    checks++;
    if (s_idx.size() - q0 != 2) begin
      failures++; $display("FAIL invalid_count got=%0d want=2", s_idx.size() - q0);
    end else if (s_idx[q0] != 0 || s_val[q0] != 0 || s_idx[q0+1] != 1 || s_val[q0+1] != 0) begin
      failures++;
      $display("FAIL invalid_samples got=(%0d,%0d)(%0d,%0d) want=(0,0)(1,0)", s_idx[q0], s_val[q0], s_idx[q0+1], s_val[q0+1]);
    end
    checks++;
    if (total_dv != dv0 || bits_left !== 12'd50) begin
      failures++; $display("FAIL invalid_bits consumed=%0d bits_left=%0d want=0/50", total_dv - dv0, bits_left);
    end
    checks++;
    if (s_tbl.size() - t0q != 1 || s_tbl[t0q] !== 5'd0) begin
      failures++; $display("FAIL invalid_ht_sel count=%0d want ht_sel 0", s_tbl.size() - t0q);
    end
  endtask

  task automatic test_reset_mid_feed;
    int dv0, d0;
    bit reached;
    stream = 32'b01011; stream_len = 8; gate_mode = 1'b0;
    need_bits = 5; model_x = 16'sd0; model_y = 16'sd1;
    dv0 = total_dv;
    do_start(9'd1, 10'd576, 10'd576, 5'd28, 5'd0, 5'd0, 12'd20);
    reached = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (total_dv - dv0 >= 2) begin
        reached = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!reached) begin failures++; $display("FAIL midfeed_two_bits got=%0d want=2", total_dv - dv0); end
    d0 = done_cnt;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy, bit_ready, dec_valid, sample_valid, done, error} !== 6'b0) begin
      failures++;
      $display("FAIL midfeed_reset_flags got=%b want=000000", {busy, bit_ready, dec_valid, sample_valid, done, error});
    end
    checks++;
    if (bits_left !== '0 || ht_sel !== '0) begin
      failures++; $display("FAIL midfeed_reset_regs bits_left=%0d ht_sel=%0d want=0/0", bits_left, ht_sel);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (done_cnt != d0 || busy !== 1'b0) begin
      failures++; $display("FAIL midfeed_no_done pulses=%0d busy=%b want=0/0", done_cnt - d0, busy);
    end
    test_single_pair("after_reset", 1'b0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; big_values = '0; region1_start = '0; region2_start = '0;
    table_sel0 = '0; table_sel1 = '0; table_sel2 = '0; bit_budget = '0;
    stream = '0; stream_len = 0; gate_mode = 1'b0;
    need_bits = 5; model_x = '0; model_y = '0;
    #1;
    test_reset;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_single_pair("single", 1'b0);
    test_region_switch;
    test_single_pair("backpressure", 1'b1);
    test_budget_exhaust;
    test_clamp;
    test_invalid_table;
    test_single_pair("back_to_back", 1'b0);
    test_reset_mid_feed;
    checks++;
    if (viol != 0) begin failures++; $display("FAIL dec_valid_protocol got=%0d want=0", viol); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
